// File: rtl/serial_alu_pkg.sv
// Shared constants for the bit-serial ALU: alu_ctl codes, cell op-selects,
// controller state encoding and the alu_ctl to cell-control decode.
package serial_alu_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        CELL_AND = 2'b00,
        CELL_OR  = 2'b01,
        CELL_ADD = 2'b10
    } cellOp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    typedef struct packed {
        logic    aInvert;
        logic    bInvert;
        logic    arith;
        cellOp_t op;
    } cellCtl_t;

    function automatic logic isLegal(input logic [3:0] ctl);
        logic legal;
        legal = 1'b0;
        case (ctl)
            CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_SLT, CTL_NOR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // NOR is De Morgan: invert both inputs and AND them
    function automatic cellCtl_t decodeCtl(input logic [3:0] ctl);
        cellCtl_t c;
        c.aInvert = 1'b0;
        c.bInvert = 1'b0;
        c.arith   = 1'b0;
        c.op      = CELL_AND;
        case (ctl)
            CTL_AND: c.op = CELL_AND;
            CTL_OR:  c.op = CELL_OR;
            CTL_ADD: begin
                c.op    = CELL_ADD;
                c.arith = 1'b1;
            end
            CTL_SUB, CTL_SLT: begin
                c.op      = CELL_ADD;
                c.arith   = 1'b1;
                c.bInvert = 1'b1;
            end
            CTL_NOR: begin
                c.op      = CELL_AND;
                c.aInvert = 1'b1;
                c.bInvert = 1'b1;
            end
            default: c.op = CELL_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_cell.sv
// One-bit ALU slice: optional input inversion, then AND, OR or full-add.
module alu_cell
    import serial_alu_pkg::*;
(
    input  logic    i_a,
    input  logic    i_b,
    input  logic    i_aInvert,
    input  logic    i_bInvert,
    input  logic    i_carryIn,
    input  cellOp_t i_op,
    output logic    o_result,
    output logic    o_carryOut
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a        = i_a ^ i_aInvert;
    assign w_b        = i_b ^ i_bInvert;
    assign w_sum      = w_a ^ w_b ^ i_carryIn;
    assign o_carryOut = (w_a & w_b) | (i_carryIn & (w_a ^ w_b));

    always_comb begin
        o_result = 1'b0;
        case (i_op)
            CELL_AND: o_result = w_a & w_b;
            CELL_OR:  o_result = w_a | w_b;
            CELL_ADD: o_result = w_sum;
            default:  o_result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: one alu_cell stepped LSB first, one bit per clock.
// Define SERIAL_ALU_FLAGS_EN to build the zero/overflow flag logic; otherwise both flags are tied to 0.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_nextState;
    logic             w_accept;
    logic             w_lastBit;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_ctl;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_msbCarryIn;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    cellCtl_t         w_cellCtl;
    cellCtl_t         w_startCtl;
    logic             w_cellRes;
    logic             w_cellCout;
    logic [WIDTH-1:0] w_runResult;
    logic             w_sltBit;

    assign w_cellCtl   = decodeCtl(r_ctl);
    assign w_startCtl  = decodeCtl(alu_ctl);
    assign w_lastBit   = (r_count == CW'(WIDTH - 1));
    assign w_runResult = r_result | ({{(WIDTH-1){1'b0}}, w_cellRes} << r_count);
    // signed less-than: sign of the difference corrected by signed overflow
    assign w_sltBit    = r_result[WIDTH-1] ^ (r_msbCarryIn ^ r_carry);

    alu_cell u_cell (
        .i_a        (r_a[r_count]),
        .i_b        (r_b[r_count]),
        .i_aInvert  (w_cellCtl.aInvert),
        .i_bInvert  (w_cellCtl.bInvert),
        .i_carryIn  (r_carry),
        .i_op       (w_cellCtl.op),
        .o_result   (w_cellRes),
        .o_carryOut (w_cellCout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = isLegal(alu_ctl) ? S_RUN : S_DONE;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_lastBit) w_nextState = (r_ctl == CTL_SLT) ? S_FIX : S_DONE;
            end
            S_FIX: begin
                busy        = 1'b1;
                w_nextState = S_DONE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_ctl        <= CTL_AND;
            r_count      <= '0;
            r_carry      <= 1'b0;
            r_msbCarryIn <= 1'b0;
            r_result     <= '0;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            r_a          <= a;
            r_b          <= b;
            r_ctl        <= alu_ctl;
            r_count      <= '0;
            r_carry      <= w_startCtl.arith & w_startCtl.bInvert;
            r_msbCarryIn <= 1'b0;
            r_result     <= '0;
            r_err        <= ~isLegal(alu_ctl);
        end else begin
            case (r_state)
                S_RUN: begin
                    r_result <= w_runResult;
                    r_carry  <= w_cellCout;
                    r_count  <= r_count + 1'b1;
                    if (w_lastBit) r_msbCarryIn <= r_carry;
                end
                S_FIX: r_result <= {{(WIDTH-1){1'b0}}, w_sltBit};
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign err    = r_err;

`ifdef SERIAL_ALU_FLAGS_EN
    logic r_zero;
    logic r_ovf;
    logic w_isAddSub;

    assign w_isAddSub = (r_ctl == CTL_ADD) || (r_ctl == CTL_SUB);

    // flags are captured as the final result is written so they hold through DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_zero <= ~isLegal(alu_ctl);
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_lastBit) begin
                        r_ovf <= w_isAddSub & (r_carry ^ w_cellCout);
                        if (r_ctl != CTL_SLT) r_zero <= (w_runResult == '0);
                    end
                end
                S_FIX: r_zero <= ~w_sltBit;
                default: ;
            endcase
        end
    end

    assign zero     = r_zero;
    assign overflow = r_ovf;
`else
    assign zero     = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed cases plus randomized ops against an arithmetic reference model.
module tb_serial_alu_ctrl;

    localparam int W = 32;
`ifdef SERIAL_ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   ctlIn;
    logic [W-1:0] aIn;
    logic [W-1:0] bIn;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;
    logic         zero;
    logic         overflow;

    int vectors;
    int miscompares;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alu_ctl  (ctlIn),
        .a        (aIn),
        .b        (bIn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isLegalOp(input logic [3:0] ctl);
        return (ctl == 4'b0000) || (ctl == 4'b0001) || (ctl == 4'b0010) ||
               (ctl == 4'b0110) || (ctl == 4'b0111) || (ctl == 4'b1100);
    endfunction

    // Reference model: plain arithmetic on whole words, latency in clock edges from the accepting edge
    function automatic void model(input logic [3:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] res, output bit e, output bit z,
                                  output bit ovf, output int lat);
        res = '0; e = 1'b0; ovf = 1'b0; lat = W + 1;
        case (ctl)
            4'b0000: res = x & y;
            4'b0001: res = x | y;
            4'b0010: begin
                res = x + y;
                ovf = (x[W-1] == y[W-1]) && (res[W-1] != x[W-1]);
            end
            4'b0110: begin
                res = x - y;
                ovf = (x[W-1] != y[W-1]) && (res[W-1] != x[W-1]);
            end
            4'b0111: begin
                res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
                lat = W + 2;
            end
            4'b1100: res = ~(x | y);
            default: begin
                e   = 1'b1;
                lat = 1;
            end
        endcase
        z   = FLAGS && (res == '0);
        ovf = FLAGS && ovf;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] ctl, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int glitchAt, input bit checkPulse);
        logic [W-1:0] expRes;
        logic [W-1:0] heldRes;
        bit expErr, expZero, expOvf, seen;
        int expLat, lat;
        model(ctl, x, y, expRes, expErr, expZero, expOvf, expLat);
        start = 1'b1; ctlIn = ctl; aIn = x; bIn = y;
        @(posedge clk); #1;
        start = 1'b0; aIn = $urandom; bIn = $urandom;
        lat = 1; seen = 1'b0;
        if (isLegalOp(ctl)) checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
        while (!seen && lat < 200) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (lat == glitchAt) begin
                    start = 1'b1; ctlIn = 4'b0010; aIn = $urandom; bIn = $urandom;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        checkOutput({tag, ".latency"},  64'(lat),      64'(expLat));
        checkOutput({tag, ".result"},   64'(result),   64'(expRes));
        checkOutput({tag, ".err"},      64'(err),      64'(expErr));
        checkOutput({tag, ".zero"},     64'(zero),     64'(expZero));
        checkOutput({tag, ".overflow"}, 64'(overflow), 64'(expOvf));
        if (checkPulse) begin
            heldRes = result;
            @(posedge clk); #1;
            checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
            checkOutput({tag, ".busyIdle"},  64'(busy), 64'd0);
            @(posedge clk); #1;
            checkOutput({tag, ".hold"},      64'(result), 64'(heldRes));
        end
    endtask

    task automatic abortRun(input string tag, input logic [3:0] ctl, input logic [W-1:0] x,
                            input logic [W-1:0] y, input int edgesBefore);
        bit seen;
        start = 1'b1; ctlIn = ctl; aIn = x; bIn = y;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (edgesBefore) @(posedge clk);
        #1;
        checkOutput({tag, ".busyBefore"}, 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, ".outputs"}, {58'd0, busy, done, err, zero, overflow, (result != '0)}, 64'd0);
        checkOutput({tag, ".result"}, 64'(result), 64'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checkOutput({tag, ".noDone"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [W-1:0] edgeVals [4];
        logic [3:0]   ops [7];
        logic [W-1:0] x, y;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; ctlIn = '0; aIn = '0; bIn = '0;
        edgeVals = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0101};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.outputs", {58'd0, busy, done, err, zero, overflow, (result != '0)}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus("addOvf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, -1, 1'b1);
        applyStimulus("subZero", 4'b0110, 32'h0000_0005, 32'h0000_0005, -1, 1'b1);
        applyStimulus("sltTrue", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, -1, 1'b1);
        applyStimulus("sltFalse",4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, -1, 1'b1);
        applyStimulus("norGlit", 4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, 11, 1'b1);
        applyStimulus("illegal", 4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, -1, 1'b1);
        applyStimulus("andB2B",  4'b0000, 32'hF0F0_1234, 32'hFF00_FF0F, -1, 1'b0);
        applyStimulus("orB2B",   4'b0001, 32'h0000_1200, 32'h8000_0034, -1, 1'b1);

        abortRun("abortRun", 4'b0010, 32'h1111_1111, 32'h2222_2222, 16);
        abortRun("abortFix", 4'b0111, 32'h8000_0000, 32'h0000_0001, W);

        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : W'($urandom);
            if ($urandom_range(0, 7) == 0) y = x;
            applyStimulus($sformatf("rand%0d", i), ops[$urandom_range(0, 6)], x, y, -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (legal values 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port alu_ctl, input, 4 bits: operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR).
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse; result and flags are valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: operation result.
REQ-011 The block SHALL have port err, output, 1 bit: the last accepted alu_ctl was illegal.
REQ-012 The block SHALL have port zero, output, 1 bit: result equals 0.
REQ-013 The block SHALL have port overflow, output, 1 bit: signed overflow of ADD or SUB.

Function
REQ-014 The block SHALL contain one 1-bit ALU cell and process one bit per clock, LSB first.
REQ-015 The state machine SHALL have four states: IDLE, RUN, FIX, DONE.
REQ-016 start SHALL be accepted only in IDLE or DONE; accepting it latches a, b and alu_ctl, clears the bit counter and the result register, and moves to RUN.
REQ-017 start SHALL be ignored while in RUN or FIX, with no effect on any state.
REQ-018 Per-operation cell control SHALL be: a_invert=1 for NOR only; b_invert=1 for SUB, SLT and NOR; initial carry-in = b_invert for arithmetic; cell op = and for AND/NOR, or for OR, adder for ADD/SUB/SLT.
REQ-019 Each RUN cycle SHALL feed bit[counter] of the latched operands to the cell, register carry-out as the next carry-in, and shift the cell result into result bit[counter].
REQ-020 After the RUN cycle for bit WIDTH-1, the block SHALL go to FIX for SLT and to DONE otherwise.
REQ-021 In FIX the block SHALL set result = {WIDTH-1 zeros, (MSB of difference XOR signed overflow)}.
REQ-022 done SHALL be high for exactly one cycle in DONE: WIDTH+1 cycles after the accepting edge for non-SLT operations, WIDTH+2 cycles for SLT.
REQ-023 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-024 DONE SHALL return to IDLE on the next cycle unless start is high, in which case it goes to RUN.
REQ-025 An illegal alu_ctl SHALL skip RUN: the block goes to DONE on the next cycle with result=0 and err=1.
REQ-026 For a legal operation, err SHALL be cleared when start is accepted.
REQ-027 result, err and the flags SHALL hold their values from DONE until the next accepted start.
REQ-028 overflow SHALL equal carry-in XOR carry-out of bit WIDTH-1 for ADD and SUB, and 0 for all other operations.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL enter IDLE; busy, done, err, zero and overflow become 0 and result becomes 0, including when reset arrives mid-RUN or mid-FIX.
REQ-030 An aborted operation SHALL produce no done pulse.

Configuration
REQ-031 Macro SERIAL_ALU_FLAGS_EN defined: zero and overflow SHALL be computed per REQ-012 and REQ-028.
REQ-032 Macro SERIAL_ALU_FLAGS_EN undefined: the zero and overflow ports SHALL remain present, tied to 0, with no flag logic.

Structure
REQ-033 A shared package serial_alu_pkg SHALL hold the alu_ctl code constants, the cell op-select constants and the state encoding.
REQ-034 The only sub-module SHALL be one instance of the existing alu_cell.
REQ-035 The counter, shift register and FSM SHALL reside in serial_alu_ctrl.

Verification
REQ-036 With WIDTH=32: ADD 0x7FFFFFFF + 0x00000001 -> result=0x80000000, overflow=1, done 33 cycles after start.
REQ-037 SUB 0x00000005 - 0x00000005 -> result=0, zero=1, overflow=0.
REQ-038 SLT a=0xFFFFFFFF, b=0x00000001 -> result=0x00000001 at cycle 34; swapped operands -> result=0x00000000.
REQ-039 NOR 0x0F0F0F0F, 0x00FF00FF -> result=0xF000F000; start pulsed at RUN cycle 10 -> ignored, single done pulse.
REQ-040 alu_ctl=0101 -> done next cycle, err=1, result=0; rst_n low at RUN cycle 16 -> IDLE, all outputs 0, no done.
